// File: rtl/micro86_memctl_pkg.sv
// rtl/micro86_memctl_pkg.sv - shared constants and types for the micro86 memory controller
// Holds bus-wide defaults and the per-cycle RAM port owner encoding.
package micro86_memctl_pkg;

   localparam int         CPU_A_W    = 20;
   localparam int         DEF_ADDR_W = 16;
   localparam logic [7:0] DEF_FILL   = 8'hFF;
   localparam int         MEM_LAT    = 1;

   typedef enum logic [1:0] {
      OWN_IDLE   = 2'd0,
      OWN_VID    = 2'd1,
      OWN_CPU_WR = 2'd2,
      OWN_CPU_RD = 2'd3
   } owner_t;

endpackage

// File: rtl/micro86_memctl.sv
// rtl/micro86_memctl.sv - micro86 CPU bus responder sharing one sync RAM port with video fetch
// CPU is throttled via cpu_ce; a one-byte read cache (la/rd) lets repeat reads complete without the port.
module micro86_memctl
   import micro86_memctl_pkg::*;
#(
   parameter int         ADDR_W = DEF_ADDR_W,
   parameter logic [7:0] FILL   = DEF_FILL
) (
   input  logic               clock,
   input  logic               reset,
   input  logic [CPU_A_W-1:0] cpu_a,
   input  logic [7:0]         cpu_o,
   input  logic               cpu_w,
   output logic [7:0]         cpu_i,
   output logic               cpu_ce,
   output logic [ADDR_W-1:0]  mem_a,
   output logic [7:0]         mem_d,
   output logic               mem_we,
   input  logic [7:0]         mem_q,
   input  logic               vid_req,
   input  logic [ADDR_W-1:0]  vid_a,
   output logic               vid_ack,
   output logic               vid_valid,
   output logic [7:0]         vid_q
);

   logic [CPU_A_W-1:0] la;
   logic               lv;
   logic [7:0]         rd;
   logic               pend;
   logic               vlast;

   logic   oor;
   logic   la_match;
   logic   hit;
   logic   need;
   logic   vid_win;
   owner_t owner;

   assign oor      = (cpu_a >> ADDR_W) != '0;
   assign la_match = lv && (cpu_a == la);
   assign hit      = !cpu_w && (oor || la_match);
   assign need     = !hit;
   // Video has priority, but never takes two slots in a row while the CPU waits.
   assign vid_win  = vid_req && !(need && vlast);

   always_comb begin
      owner = OWN_IDLE;
      if (vid_win)
         owner = OWN_VID;
      else if (cpu_w)
         owner = OWN_CPU_WR;
      else if (need)
         owner = OWN_CPU_RD;
   end

   assign cpu_ce  = hit || (cpu_w && !vid_win);
   assign cpu_i   = oor ? FILL : (pend ? mem_q : rd);
   assign mem_a   = (owner == OWN_VID) ? vid_a : cpu_a[ADDR_W-1:0];
   assign mem_d   = cpu_o;
   assign mem_we  = (owner == OWN_CPU_WR) && !oor;
   assign vid_ack = (owner == OWN_VID);
   assign vid_q   = mem_q;

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         la        <= '0;
         lv        <= 1'b0;
         rd        <= FILL;
         pend      <= 1'b0;
         vlast     <= 1'b0;
         vid_valid <= 1'b0;
      end else begin
         vlast     <= (owner == OWN_VID);
         vid_valid <= (owner == OWN_VID);
         if (pend) begin
            rd   <= mem_q;
            pend <= 1'b0;
         end
         case (owner)
            OWN_CPU_WR: begin
               // Keep the cached byte coherent with a write to the latched address.
               if (!oor && la_match) begin
                  rd   <= cpu_o;
                  pend <= 1'b0;
               end
            end
            OWN_CPU_RD: begin
               la   <= cpu_a;
               lv   <= 1'b1;
               pend <= 1'b1;
            end
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_micro86_memctl.sv
// tb/tb_micro86_memctl.sv - self-checking bench for micro86_memctl with a 1-cycle sync RAM model
// Expected CPU and video bytes come from a reference memory and are queued when stimulus is driven.
module tb_micro86_memctl;

   logic        clock;
   logic        reset;
   logic [19:0] cpu_a;
   logic [7:0]  cpu_o;
   logic        cpu_w;
   logic [7:0]  cpu_i;
   logic        cpu_ce;
   logic [15:0] mem_a;
   logic [7:0]  mem_d;
   logic        mem_we;
   logic [7:0]  mem_q;
   logic        vid_req;
   logic [15:0] vid_a;
   logic        vid_ack;
   logic        vid_valid;
   logic [7:0]  vid_q;

   logic [7:0] ram     [0:65535];
   logic [7:0] ref_mem [0:65535];
   logic [7:0] cq [$];
   logic [7:0] vq [$];
   int         vectors = 0;
   int         errors  = 0;
   logic       exp_vv  = 1'b0;
   logic       rand_vid = 1'b0;

   micro86_memctl dut (
      .clock    (clock),
      .reset    (reset),
      .cpu_a    (cpu_a),
      .cpu_o    (cpu_o),
      .cpu_w    (cpu_w),
      .cpu_i    (cpu_i),
      .cpu_ce   (cpu_ce),
      .mem_a    (mem_a),
      .mem_d    (mem_d),
      .mem_we   (mem_we),
      .mem_q    (mem_q),
      .vid_req  (vid_req),
      .vid_a    (vid_a),
      .vid_ack  (vid_ack),
      .vid_valid(vid_valid),
      .vid_q    (vid_q)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [7:0] init_byte(input int i);
      logic [15:0] a;
      a = 16'(i);
      return a[7:0] ^ a[15:8] ^ 8'h78;
   endfunction

   initial begin
      for (int i = 0; i < 65536; i++) ram[i] <= init_byte(i);
   end

   always @(posedge clock) begin
      if (mem_we) ram[mem_a] <= mem_d;
      mem_q <= ram[mem_a];
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [19:0] pick_addr();
      int r;
      r = $urandom_range(0, 9);
      if (r == 0) return 20'hA0000 | 20'($urandom_range(0, 255));
      if (r == 1) return 20'($urandom_range(0, 65535));
      return 20'h00010 + 20'($urandom_range(0, 7));
   endfunction

   // Called just after a negedge: evaluate this cycle's outputs and account for what commits at the next posedge.
   task automatic settle();
      logic in_rng;
      if (rand_vid) begin
         vid_req = 1'($urandom_range(0, 1));
         vid_a   = 16'h0010 + 16'($urandom_range(0, 7));
      end
      #1;
      if (exp_vv) begin
         chk("vid_valid", 32'(vid_valid), 32'd1);
         if (vq.size() > 0) chk("vid_q", 32'(vid_q), 32'(vq.pop_front()));
         else chk("vid_q_underflow", 32'd0, 32'd1);
      end else begin
         chk("vid_valid_idle", 32'(vid_valid), 32'd0);
      end
      exp_vv = vid_ack;
      if (vid_ack) begin
         chk("vid_ack_mem_a", 32'(mem_a), 32'(vid_a));
         vq.push_back(ref_mem[vid_a]);
      end
      in_rng = (cpu_a < 20'h10000);
      chk("mem_we", 32'(mem_we), 32'(cpu_ce && cpu_w && in_rng));
      if (cpu_ce && cpu_w && in_rng) ref_mem[cpu_a[15:0]] = cpu_o;
   endtask

   task automatic cpu_read(input logic [19:0] a, input int max_stall);
      int   stalls;
      logic done;
      cpu_a = a;
      cpu_w = 1'b0;
      cq.push_back((a >= 20'h10000) ? 8'hFF : ref_mem[a[15:0]]);
      stalls = 0;
      done   = 1'b0;
      while (!done && stalls <= 4) begin
         settle();
         if (cpu_ce) begin
            chk("cpu_i", 32'(cpu_i), 32'(cq.pop_front()));
            done = 1'b1;
         end else begin
            stalls++;
         end
         @(negedge clock);
      end
      if (!done) void'(cq.pop_front());
      chk("rd_stall_bound", 32'(stalls <= max_stall), 32'd1);
   endtask

   task automatic cpu_write(input logic [19:0] a, input logic [7:0] d, input int max_stall);
      int   stalls;
      logic done;
      cpu_a  = a;
      cpu_o  = d;
      cpu_w  = 1'b1;
      stalls = 0;
      done   = 1'b0;
      while (!done && stalls <= 4) begin
         settle();
         if (cpu_ce) done = 1'b1;
         else stalls++;
         @(negedge clock);
      end
      cpu_w = 1'b0;
      chk("wr_stall_bound", 32'(stalls <= max_stall), 32'd1);
   endtask

   initial begin
      for (int i = 0; i < 65536; i++) ref_mem[i] = init_byte(i);
      reset   = 1'b1;
      cpu_a   = 20'h00123;
      cpu_o   = 8'h00;
      cpu_w   = 1'b0;
      vid_req = 1'b0;
      vid_a   = 16'h0000;

      // Reset state
      @(negedge clock);
      #1;
      chk("rst_ce", 32'(cpu_ce), 32'd0);
      chk("rst_we", 32'(mem_we), 32'd0);
      chk("rst_vid_ack", 32'(vid_ack), 32'd0);
      chk("rst_vid_valid", 32'(vid_valid), 32'd0);
      chk("rst_cpu_i", 32'(cpu_i), 32'hFF);
      @(negedge clock);
      reset = 1'b0;

      // New-address read: one stall, then hit with no port use
      settle();
      chk("t1_c0_ce", 32'(cpu_ce), 32'd0);
      chk("t1_c0_mem_a", 32'(mem_a), 32'h0123);
      @(negedge clock);
      settle();
      chk("t1_c1_ce", 32'(cpu_ce), 32'd1);
      chk("t1_c1_cpu_i", 32'(cpu_i), 32'h5A);
      @(negedge clock);
      settle();
      chk("t1_c2_ce", 32'(cpu_ce), 32'd1);
      chk("t1_c2_cpu_i", 32'(cpu_i), 32'h5A);
      chk("t1_c2_we", 32'(mem_we), 32'd0);
      @(negedge clock);

      // Write to the cached address, then zero-stall read back
      cpu_write(20'h00123, 8'hC3, 0);
      cpu_read(20'h00123, 0);

      // Out-of-range read and dropped write
      cpu_read(20'hF0000, 0);
      cpu_write(20'hF0000, 8'h11, 0);
      cpu_read(20'h00123, 0);

      // Video held on 0x8000 against a CPU miss
      vid_req = 1'b1;
      vid_a   = 16'h8000;
      cpu_read(20'h04567, 2);
      cpu_read(20'h04567, 0);
      cpu_write(20'h04568, 8'h77, 1);
      cpu_read(20'h04568, 2);
      cpu_read(20'h08000, 2);
      vid_req = 1'b0;
      settle();
      @(negedge clock);
      settle();
      @(negedge clock);

      // Reset while a read is pending
      cpu_a = 20'h00200;
      cpu_w = 1'b0;
      settle();
      chk("t5_issue_ce", 32'(cpu_ce), 32'd0);
      @(posedge clock);
      #2;
      reset = 1'b1;
      #1;
      chk("t5_rst_ce", 32'(cpu_ce), 32'd0);
      chk("t5_rst_vid_valid", 32'(vid_valid), 32'd0);
      chk("t5_rst_cpu_i", 32'(cpu_i), 32'hFF);
      exp_vv = 1'b0;
      vq.delete();
      @(negedge clock);
      reset = 1'b0;
      settle();
      chk("t5_refetch_ce", 32'(cpu_ce), 32'd0);
      chk("t5_refetch_mem_a", 32'(mem_a), 32'h0200);
      @(negedge clock);
      settle();
      chk("t5_data_ce", 32'(cpu_ce), 32'd1);
      chk("t5_data_cpu_i", 32'(cpu_i), 32'(ref_mem[16'h0200]));
      @(negedge clock);

      // Random CPU and video traffic on a small shared address pool
      rand_vid = 1'b1;
      for (int n = 0; n < 300; n++) begin
         if ($urandom_range(0, 3) == 0)
            cpu_write(pick_addr(), 8'($urandom_range(0, 255)), 1);
         else
            cpu_read(pick_addr(), 2);
      end
      rand_vid = 1'b0;
      vid_req  = 1'b0;
      for (int i = 0; i < 65536; i++) begin
         if (i >= 16'h0010 && i <= 16'h0017)
            chk("final_ram", 32'(ram[i]), 32'(ref_mem[i]));
      end

      $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
      $finish;
   end

endmodule
